// File: rtl/lab_counter_pkg.sv
// rtl/lab_counter_pkg.sv - shared boundary-mode and direction constants for lab counters
package lab_counter_pkg;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SAT      = 1;
    localparam int MODE_PINGPONG = 2;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_next_calc.sv
// rtl/updown_next_calc.sv - combinational next-count, boundary-hit and reversal calculation
module updown_next_calc
    import lab_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 15,
    parameter int MODE    = MODE_WRAP
) (
    input  logic [WIDTH-1:0] cur_val,
    input  logic             d,
    output logic [WIDTH-1:0] next_val,
    output logic             dir_flip,
    output logic             bound_hit
);

    // One extra bit so MAX_VAL = 2^WIDTH-1 plus one cannot alias to zero.
    localparam logic [WIDTH:0] MIN_EXT = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);

    logic [WIDTH:0] cur_ext;
    logic [WIDTH:0] inc_ext;
    logic [WIDTH:0] dec_ext;
    logic [WIDTH:0] next_ext;
    logic           unused_carry;

    assign cur_ext = {1'b0, cur_val};
    assign inc_ext = cur_ext + 1'b1;
    assign dec_ext = cur_ext - 1'b1;

    // Step in direction d; at a bound apply the mode's wrap, pin or reverse rule.
    always_comb begin
        next_ext  = d ? inc_ext : dec_ext;
        dir_flip  = 1'b0;
        bound_hit = d ? (cur_ext == MAX_EXT) : (cur_ext == MIN_EXT);
        if (bound_hit) begin
            if (MODE == MODE_WRAP) begin
                next_ext = d ? MIN_EXT : MAX_EXT;
            end else if (MODE == MODE_SAT) begin
                next_ext = cur_ext;
            end else begin
                // Reverse without dwelling on the bound: MAX -> MAX-1, MIN -> MIN+1.
                next_ext = d ? dec_ext : inc_ext;
                dir_flip = 1'b1;
            end
        end
    end

    // Every path above lands inside [MIN, MAX], so the top bit is always zero.
    assign next_val     = next_ext[WIDTH-1:0];
    assign unused_carry = next_ext[WIDTH];

endmodule

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - bounded up/down counter with load, wrap/saturate/ping-pong and tc pulse
module param_updown_counter
    import lab_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 15,
    parameter int MODE    = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] out,
    output logic             cur_dir,
    output logic             tc
);

    if (MIN_VAL < 0 || MIN_VAL >= MAX_VAL ||
        64'(MAX_VAL) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_bounds
        $error("param_updown_counter: need 0 <= MIN_VAL < MAX_VAL <= 2^WIDTH-1");
    end
    if (MODE < MODE_WRAP || MODE > MODE_PINGPONG) begin : g_bad_mode
        $error("param_updown_counter: MODE must be 0, 1 or 2");
    end

    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   MIN_EXT = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);

    logic [WIDTH-1:0] out_q, out_d;
    logic             cur_dir_q, cur_dir_d;
    logic             tc_q, tc_d;

    logic             eff_dir;
    logic [WIDTH-1:0] calc_next;
    logic             calc_flip;
    logic             calc_hit;
    logic [WIDTH:0]   data_ext;
    logic [WIDTH-1:0] data_clamped;

    // Ping-pong steers from its own registered direction; the other modes follow dir.
    assign eff_dir = (MODE == MODE_PINGPONG) ? cur_dir_q : dir;

    updown_next_calc #(
        .WIDTH   (WIDTH),
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL),
        .MODE    (MODE)
    ) u_next_calc (
        .cur_val   (out_q),
        .d         (eff_dir),
        .next_val  (calc_next),
        .dir_flip  (calc_flip),
        .bound_hit (calc_hit)
    );

    // Clamp load data into range; the low test is written as data+1 <= MIN so it
    // stays a real compare when MIN_VAL is zero.
    always_comb begin
        data_ext     = {1'b0, data};
        data_clamped = data;
        if ((data_ext + 1'b1) <= MIN_EXT) begin
            data_clamped = MIN_W;
        end else if (data_ext > MAX_EXT) begin
            data_clamped = MAX_W;
        end
    end

    // Priority load > en > hold; tc only pulses on an enabled boundary hit.
    always_comb begin
        out_d     = out_q;
        cur_dir_d = cur_dir_q;
        tc_d      = 1'b0;
        if (load) begin
            out_d     = data_clamped;
            cur_dir_d = dir;
        end else if (en) begin
            out_d = calc_next;
            tc_d  = calc_hit;
            if (MODE == MODE_PINGPONG) begin
                cur_dir_d = cur_dir_q ^ calc_flip;
            end else begin
                cur_dir_d = dir;
            end
        end else if (MODE != MODE_PINGPONG) begin
            cur_dir_d = dir;
        end
    end

    // State registers; reset returns to MIN_VAL counting up with no pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= MIN_W;
            cur_dir_q <= DIR_UP;
            tc_q      <= 1'b0;
        end else begin
            out_q     <= out_d;
            cur_dir_q <= cur_dir_d;
            tc_q      <= tc_d;
        end
    end

    assign out     = out_q;
    assign cur_dir = cur_dir_q;
    assign tc      = tc_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - scoreboard bench over wrap, saturate, ping-pong and full-range counters
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en   [4];
    logic       dir  [4];
    logic       load [4];
    logic [3:0] data [4];
    logic [3:0] q    [4];
    logic       cd   [4];
    logic       tcp  [4];

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(12), .MODE(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en[0]), .dir(dir[0]), .load(load[0]), .data(data[0]),
        .out(q[0]), .cur_dir(cd[0]), .tc(tcp[0]));
    param_updown_counter #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(12), .MODE(1)) u_sat (
        .clk(clk), .rst(rst), .en(en[1]), .dir(dir[1]), .load(load[1]), .data(data[1]),
        .out(q[1]), .cur_dir(cd[1]), .tc(tcp[1]));
    param_updown_counter #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(12), .MODE(2)) u_pp (
        .clk(clk), .rst(rst), .en(en[2]), .dir(dir[2]), .load(load[2]), .data(data[2]),
        .out(q[2]), .cur_dir(cd[2]), .tc(tcp[2]));
    param_updown_counter #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(15), .MODE(0)) u_full (
        .clk(clk), .rst(rst), .en(en[3]), .dir(dir[3]), .load(load[3]), .data(data[3]),
        .out(q[3]), .cur_dir(cd[3]), .tc(tcp[3]));

    typedef struct {
        int         k;
        logic [3:0] o;
        logic       c;
        logic       t;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input int k, input logic [3:0] o, input logic c, input logic t,
                         input string tag);
        n_vec++;
        if (q[k] !== o || cd[k] !== c || tcp[k] !== t) begin
            n_miss++;
            $display("FAIL %s dut%0d: got out=%0d cur_dir=%b tc=%b, want out=%0d cur_dir=%b tc=%b",
                     tag, k, q[k], cd[k], tcp[k], o, c, t);
        end
    endtask

    // Drive one DUT for the coming edge and queue what it must show after that edge.
    task automatic step(input int k, input logic e, input logic d, input logic l,
                        input logic [3:0] v, input logic [3:0] o, input logic c,
                        input logic t, input string tag);
        exp_t x;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            en[i]   = 1'b0;
            load[i] = 1'b0;
        end
        en[k]   = e;
        dir[k]  = d;
        load[k] = l;
        data[k] = v;
        x.k = k; x.o = o; x.c = c; x.t = t; x.tag = tag;
        sb.push_back(x);
    endtask

    // Monitor: after every rising edge, compare whatever the stimulus queued for it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.k, e.o, e.c, e.t, e.tag);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            en[i] = 1'b0; dir[i] = 1'b0; load[i] = 1'b0; data[i] = 4'd0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check(0, 4'd2, 1'b1, 1'b0, "reset_wrap");
        check(1, 4'd2, 1'b1, 1'b0, "reset_sat");
        check(2, 4'd2, 1'b1, 1'b0, "reset_pp");
        check(3, 4'd0, 1'b1, 1'b0, "reset_full");
        rst = 1'b0;

        // Async reset mid-count at 7, between edges.
        for (int v = 3; v <= 7; v++) step(0, 1, 1, 0, 4'd0, 4'(v), 1, 0, "count_to_7");
        @(posedge clk);
        #3;
        en[0] = 1'b0;
        rst   = 1'b1;
        #1;
        check(0, 4'd2, 1'b1, 1'b0, "async_rst_midcount");
        @(negedge clk);
        rst = 1'b0;

        // Wrap mode up and down.
        for (int v = 3; v <= 12; v++) step(0, 1, 1, 0, 4'd0, 4'(v), 1, 0, "wrap_up");
        step(0, 1, 1, 0, 4'd0, 4'd2,  1, 1, "wrap_max_to_min");
        step(0, 1, 1, 0, 4'd0, 4'd3,  1, 0, "wrap_after_tc");
        step(0, 1, 0, 0, 4'd0, 4'd2,  0, 0, "wrap_down");
        step(0, 1, 0, 0, 4'd0, 4'd12, 0, 1, "wrap_min_to_max");
        step(0, 1, 0, 0, 4'd0, 4'd11, 0, 0, "wrap_down_after_tc");

        // Load clamp and load-over-enable.
        step(0, 0, 1, 1, 4'd0,  4'd2,  1, 0, "clamp_low");
        step(0, 0, 0, 1, 4'd15, 4'd12, 0, 0, "clamp_high");
        step(0, 0, 1, 1, 4'd5,  4'd5,  1, 0, "load_5");
        step(0, 1, 1, 1, 4'd9,  4'd9,  1, 0, "load_beats_en");

        // Saturate mode.
        step(1, 0, 1, 1, 4'd10, 4'd10, 1, 0, "sat_load10");
        step(1, 1, 1, 0, 4'd0,  4'd11, 1, 0, "sat_up11");
        step(1, 1, 1, 0, 4'd0,  4'd12, 1, 0, "sat_up12");
        step(1, 1, 1, 0, 4'd0,  4'd12, 1, 1, "sat_pinned_max1");
        step(1, 1, 1, 0, 4'd0,  4'd12, 1, 1, "sat_pinned_max2");
        step(1, 1, 1, 1, 4'd12, 4'd12, 1, 0, "sat_load_en_at_max");
        step(1, 0, 0, 1, 4'd2,  4'd2,  0, 0, "sat_load2");
        step(1, 1, 0, 0, 4'd0,  4'd2,  0, 1, "sat_pinned_min1");
        step(1, 1, 0, 0, 4'd0,  4'd2,  0, 1, "sat_pinned_min2");
        step(1, 0, 0, 0, 4'd0,  4'd2,  0, 0, "sat_hold");
        step(1, 0, 1, 0, 4'd0,  4'd2,  1, 0, "sat_hold_dir_follows");

        // Ping-pong mode.
        step(2, 0, 1, 1, 4'd11, 4'd11, 1, 0, "pp_load11");
        step(2, 1, 1, 0, 4'd0,  4'd12, 1, 0, "pp_up12");
        step(2, 1, 1, 0, 4'd0,  4'd11, 0, 1, "pp_reverse_at_max");
        step(2, 1, 1, 0, 4'd0,  4'd10, 0, 0, "pp_down10");
        step(2, 1, 1, 0, 4'd0,  4'd9,  0, 0, "pp_dir_ignored");
        step(2, 0, 1, 0, 4'd0,  4'd9,  0, 0, "pp_hold_dir_ignored");
        step(2, 0, 0, 1, 4'd3,  4'd3,  0, 0, "pp_load3_down");
        step(2, 1, 0, 0, 4'd0,  4'd2,  0, 0, "pp_down2");
        step(2, 1, 0, 0, 4'd0,  4'd3,  1, 1, "pp_reverse_at_min");
        step(2, 1, 0, 0, 4'd0,  4'd4,  1, 0, "pp_up4");
        step(2, 1, 0, 0, 4'd0,  4'd5,  1, 0, "pp_up5_dir_ignored");

        // Full 4-bit range wrap.
        step(3, 0, 1, 1, 4'd15, 4'd15, 1, 0, "full_load15");
        step(3, 1, 1, 0, 4'd0,  4'd0,  1, 1, "full_15_to_0");
        step(3, 1, 0, 0, 4'd0,  4'd15, 0, 1, "full_0_to_15");
        step(3, 1, 1, 0, 4'd0,  4'd0,  1, 1, "full_15_to_0_again");
        step(3, 1, 1, 0, 4'd0,  4'd1,  1, 0, "full_up1");
        for (int i = 0; i < 3; i++) step(3, 0, 1, 0, 4'd0, 4'd1, 1, 0, "full_hold");

        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            en[i]   = 1'b0;
            load[i] = 1'b0;
        end
        @(posedge clk);
        #2;
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised up/down counter with synchronous load, programmable bounds and three boundary modes: wrap, saturate, and ping-pong (auto-reversing). It generalises the lab 4-bit load/up/down counter to arbitrary width and range. It adds a terminal-count pulse and a registered effective direction. It is used as the standard counting primitive for later lab blocks (display scanners, timers).

Parameters:
WIDTH, 4, counter width in bits
MIN_VAL, 0, lower bound (inclusive); reset value
MAX_VAL, 15, upper bound (inclusive); must satisfy MIN_VAL < MAX_VAL <= 2^WIDTH-1, elaboration error otherwise
MODE, 0, boundary behaviour: 0 wrap, 1 saturate, 2 ping-pong

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
en  input  1  count enable
dir  input  1  requested direction, 1 up / 0 down (modes 0/1 directly; mode 2 only on load)
load  input  1  synchronous load, priority over en
data  input  WIDTH  load value
out  output  WIDTH  registered count
cur_dir  output  1  registered effective direction (1 up)
tc  output  1  registered one-cycle terminal-count pulse

Behaviour:
- Reset (async, rst=1): out=MIN_VAL, cur_dir=1, tc=0. Held while rst=1; first update on first rising clk after release. Reset mid-count aborts immediately, with no pulse generated.
- Priority per rising edge: load > en > hold.
- load=1: out <= data clamped to [MIN_VAL, MAX_VAL] (data<MIN → MIN, data>MAX → MAX). cur_dir <= dir. tc <= 0. en is ignored that cycle.
- en=0, load=0: out holds. tc <= 0. In modes 0/1, cur_dir <= dir; in mode 2, cur_dir holds.
- en=1, load=0: let d = dir (modes 0/1) or cur_dir (mode 2). A boundary hit means d=1 with out==MAX_VAL, or d=0 with out==MIN_VAL.
  - No boundary hit: out <= out±1. tc <= 0.
  - Boundary hit, mode 0: out <= opposite bound (MAX→MIN, MIN→MAX). tc <= 1.
  - Boundary hit, mode 1: out holds at bound. tc <= 1 on every enabled cycle while pinned.
  - Boundary hit, mode 2: cur_dir <= ~cur_dir and out <= out∓1 in the same cycle (reversal without dwell; sequence …,MAX-1,MAX,MAX-1,…). tc <= 1.
- Out-of-range state is impossible: all paths keep MIN_VAL <= out <= MAX_VAL.
- Latency: one clock from input sample to out/tc/cur_dir update. All outputs are registered with no combinational input→output paths.
- Arithmetic is done at WIDTH+1 bits internally so MAX_VAL = 2^WIDTH-1 does not overflow before the bound compare.
- Simultaneous load+en: load wins, tc=0.
- Changing dir in mode 2 without load has no effect.

Decomposition:
- Shared package lab_counter_pkg:
  - localparams MODE_WRAP=0, MODE_SAT=1, MODE_PINGPONG=2
  - DIR_UP=1, DIR_DOWN=0
- One combinational sub-module, updown_next_calc: inputs out, d, MODE/bounds; outputs next value, direction flip and boundary-hit flags.
- The top holds the registers, load clamp and priority logic.

Test Plan (WIDTH=4, MIN_VAL=2, MAX_VAL=12 unless noted):
1. Assert rst mid-count at out=7, asynchronously between edges → out=2, cur_dir=1, tc=0 immediately, before the next clk edge.
2. MODE=0, en=1, dir=1, from reset → out steps 2..12, then 2; tc high exactly the cycle out shows 2 after 12. Same with dir=0: 2→12 with tc pulse.
3. MODE=1, load data=10, then en=1 dir=1 → 11, 12, 12, 12; tc=1 on each pinned cycle, 0 otherwise. dir=0 from 2 → stays 2, tc=1.
4. MODE=2, load data=11 dir=1, en=1 → 12, 11, 10; cur_dir goes 0 on the edge producing 11, tc pulse on that edge. Toggling dir without load → no change.
5. Load clamp: data=0 → out=2; data=15 → out=12. load=1 with en=1 at out=5 → out=data value, not data±1, tc=0.
6. WIDTH=4, MIN_VAL=0, MAX_VAL=15, MODE=0, dir=1 from 15 → 0 with tc=1, no X. en=0 for 3 cycles → out holds, tc=0.
